sd_spi_cmd_frame_rx: RTL

Parametrised SD-over-SPI command-frame receiver, successor to the fixed 6/32-bit SpiReceiver. It deserialises start, transmission, command, argument, CRC7 and end bits from the host, verifies CRC7, and flags framing errors. Completed frames go to card-side control logic through a one-entry valid/ready buffer. It sits between the SPI pins and the command decoder, clocked directly by the SPI clock.

---
 rtl/sd_spi_pkg.sv | 8 +
 rtl/sd_crc7_serial.sv | 24 ++
 rtl/sd_spi_cmd_frame_rx.sv | 123 ++++++++++++
 3 files changed

// File: rtl/sd_spi_pkg.sv
// sd_spi_pkg: shared types, constants and helpers for the SD-over-SPI receive path
package sd_spi_pkg;
   typedef enum logic [2:0] {S_IDLE, S_TXBIT, S_CMD, S_ARG, S_CRC, S_END} state_t;
   localparam logic [6:0] CRC7_POLY = 7'h09;
   function automatic int frame_bits(input int cmd_w, input int arg_w);
      return 2 + cmd_w + arg_w + 7 + 1;
   endfunction
endpackage

// File: rtl/sd_crc7_serial.sv
// sd_crc7_serial: bit-serial CRC7 (x^7+x^3+1, init 0); clear with enable restarts from zero and absorbs the bit
module sd_crc7_serial
   import sd_spi_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic       clear,
   input  logic       enable,
   input  logic       data,
   output logic [6:0] crc
);
   logic [6:0] base;
   logic       fb;
   // Select the starting value and the feedback bit for this step
   always_comb begin
      base = clear ? 7'h00 : crc;
      fb   = base[6] ^ data;
   end
   // Advance the LFSR on enable, or zero it on a bare clear
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) crc <= 7'h00;
      else if (clear || enable) crc <= enable ? ({base[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00)) : 7'h00;
   end
endmodule

// File: rtl/sd_spi_cmd_frame_rx.sv
// sd_spi_cmd_frame_rx: SD-over-SPI command-frame deserialiser with CRC7 check and one-entry output buffer
module sd_spi_cmd_frame_rx
   import sd_spi_pkg::*;
#(
   parameter int CMD_WIDTH = 6,
   parameter int ARG_WIDTH = 32,
   parameter int CRC_EN    = 1,
   parameter int LSB_FIRST = 0
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 io_SPI_CS,
   input  logic                 io_SPI_DI,
   output logic                 io_SPI_DO,
   output logic                 io_valid,
   input  logic                 io_ready,
   output logic [CMD_WIDTH-1:0] io_Command,
   output logic [ARG_WIDTH-1:0] io_CommandArgument,
   output logic                 io_CrcOk,
   output logic                 io_FrameError,
   output logic                 io_Overrun,
   output logic                 io_Busy
);
   localparam int MAX_CA = (CMD_WIDTH > ARG_WIDTH) ? CMD_WIDTH : ARG_WIDTH;
   localparam int MAX_W  = (MAX_CA > 7) ? MAX_CA : 7;
   localparam int CNT_W  = $clog2(MAX_W);

   state_t               state, next;
   logic [CNT_W-1:0]     cnt;
   logic [CMD_WIDTH-1:0] cmd_sr;
   logic [ARG_WIDTH-1:0] arg_sr;
   logic [6:0]           crc_sr, crc_calc;
   logic                 done, frame_err, crc_clr, crc_en;

   assign io_SPI_DO = 1'b1;
   assign io_Busy   = state != S_IDLE;
   assign crc_clr   = state == S_IDLE;
   assign crc_en    = !io_SPI_CS && ((state == S_IDLE && !io_SPI_DI) || state == S_TXBIT ||
                                     state == S_CMD || state == S_ARG);

   sd_crc7_serial u_crc (
      .clock  (clock),
      .reset  (reset),
      .clear  (crc_clr),
      .enable (crc_en),
      .data   (io_SPI_DI),
      .crc    (crc_calc)
   );

   // State register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else state <= next;
   end

   // Next-state decode plus frame-complete and framing-error strobes; CS high aborts silently
   always_comb begin
      next      = state;
      done      = 1'b0;
      frame_err = 1'b0;
      if (io_SPI_CS) next = S_IDLE;
      else begin
         case (state)
            S_IDLE:  next = io_SPI_DI ? S_IDLE : S_TXBIT;
            S_TXBIT: begin
               next      = io_SPI_DI ? S_CMD : S_IDLE;
               frame_err = !io_SPI_DI;
            end
            S_CMD:   next = (cnt == CNT_W'(CMD_WIDTH - 1)) ? S_ARG : S_CMD;
            S_ARG:   next = (cnt == CNT_W'(ARG_WIDTH - 1)) ? S_CRC : S_ARG;
            S_CRC:   next = (cnt == CNT_W'(6)) ? S_END : S_CRC;
            S_END: begin
               next      = S_IDLE;
               done      = io_SPI_DI;
               frame_err = !io_SPI_DI;
            end
            default: next = S_IDLE;
         endcase
      end
   end

   // Bit counter restarts on every state entry and idles at zero
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) cnt <= '0;
      else cnt <= (next != state || state == S_IDLE) ? '0 : cnt + 1'b1;
   end

   // Field shift registers; command/argument direction is selectable, CRC is always MSB-first
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cmd_sr <= '0;
         arg_sr <= '0;
         crc_sr <= '0;
      end else begin
         if (state == S_CMD)
            cmd_sr <= (LSB_FIRST != 0) ? {io_SPI_DI, cmd_sr[CMD_WIDTH-1:1]} : {cmd_sr[CMD_WIDTH-2:0], io_SPI_DI};
         if (state == S_ARG)
            arg_sr <= (LSB_FIRST != 0) ? {io_SPI_DI, arg_sr[ARG_WIDTH-1:1]} : {arg_sr[ARG_WIDTH-2:0], io_SPI_DI};
         if (state == S_CRC) crc_sr <= {crc_sr[5:0], io_SPI_DI};
      end
   end

   // Output buffer: load when empty or draining this cycle, otherwise drop and flag overrun
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         io_valid           <= 1'b0;
         io_Command         <= '0;
         io_CommandArgument <= '0;
         io_CrcOk           <= 1'b0;
         io_FrameError      <= 1'b0;
         io_Overrun         <= 1'b0;
      end else begin
         io_FrameError <= frame_err;
         io_Overrun    <= done && io_valid && !io_ready;
         if (done && (!io_valid || io_ready)) begin
            io_valid           <= 1'b1;
            io_Command         <= cmd_sr;
            io_CommandArgument <= arg_sr;
            io_CrcOk           <= (CRC_EN == 0) || (crc_sr == crc_calc);
         end else if (io_valid && io_ready) io_valid <= 1'b0;
      end
   end
endmodule
